// File: rtl/bcd_step_sequencer_if.sv
// Control and step-code bundle for the BCD step sequencer.
// The slave side is the sequencer; the master side is whoever drives the controls.
interface bcd_step_sequencer_if;
    logic ce;
    logic start;
    logic hold;
    logic abort;
    logic a;
    logic b;
    logic c;
    logic d;
    logic busy;
    logic held;
    logic step_strobe;
    logic done;

    modport slave (
        input  ce, start, hold, abort,
        output a, b, c, d, busy, held, step_strobe, done
    );

    modport master (
        output ce, start, hold, abort,
        input  a, b, c, d, busy, held, step_strobe, done
    );
endinterface

// File: rtl/bcd_step_sequencer.sv
// Runs a BCD step code 0..LAST_STEP, each step lasting PRESCALE enabled cycles,
// with hold/abort control. Code 4'b1111 blanks the downstream decoder when idle.
module bcd_step_sequencer #(
    parameter int unsigned LAST_STEP = 9,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_step_sequencer_if.slave  bus
);

    localparam int unsigned STEP_W   = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned LAST_EFF = (LAST_STEP > 9) ? 9 : LAST_STEP;
    localparam int unsigned PRE_EFF  = (PRESCALE == 0) ? 1 :
                                       ((PRESCALE > 256) ? 256 : PRESCALE);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAST_EFF);
    localparam logic [STEP_W-1:0] CODE_IDLE = STEP_W'(15);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(PRE_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   code_q, code_d;
    logic                busy_q, busy_d;
    logic                held_q, held_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;

    logic                at_tc;
    logic                at_last;

    assign at_tc   = (cnt_q == CNT_MAX);
    assign at_last = (step_q == STEP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            cnt_q    <= '0;
            code_q   <= CODE_IDLE;
            busy_q   <= 1'b0;
            held_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            busy_q   <= busy_d;
            held_q   <= held_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    // Leaving HOLD shares the RUN prescale path so held cycles stretch the step exactly.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        if (bus.abort) begin
            state_d = ST_IDLE;
            step_d  = '0;
            cnt_d   = '0;
        end else if (bus.ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d  = ST_RUN;
                        step_d   = '0;
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (bus.hold) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        if (at_tc) begin
                            cnt_d = '0;
                            if (at_last) begin
                                state_d = ST_IDLE;
                                step_d  = '0;
                                done_d  = 1'b1;
                            end else begin
                                step_d   = step_q + STEP_W'(1);
                                strobe_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        code_d = (state_d == ST_IDLE) ? CODE_IDLE : step_d;
        busy_d = (state_d != ST_IDLE);
        held_d = (state_d == ST_HOLD);
    end

    assign bus.a           = code_q[0];
    assign bus.b           = code_q[1];
    assign bus.c           = code_q[2];
    assign bus.d           = code_q[3];
    assign bus.busy        = busy_q;
    assign bus.held        = held_q;
    assign bus.step_strobe = strobe_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_bcd_step_sequencer.sv
// Bench for bcd_step_sequencer: four parameterisations driven by common stimulus,
// directed vectors plus randomized traffic against a step/remaining-cycles model.
module tb_bcd_step_sequencer;

    localparam int NDUT = 4;
    localparam int unsigned LP_LAST [NDUT] = '{9, 2, 5, 12};
    localparam int unsigned LP_PRE  [NDUT] = '{1, 3, 2, 0};

    logic clk;
    logic rst;
    logic ce;
    logic st;
    logic hd;
    logic ab;

    // {done, step_strobe, held, busy, d, c, b, a}
    logic [7:0] obs [NDUT];

    int total = 0;
    int bad   = 0;
    bit chk_model = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bcd_step_sequencer_if u_if();
        assign u_if.ce    = ce;
        assign u_if.start = st;
        assign u_if.hold  = hd;
        assign u_if.abort = ab;
        assign obs[g] = {u_if.done, u_if.step_strobe, u_if.held, u_if.busy,
                         u_if.d, u_if.c, u_if.b, u_if.a};
        bcd_step_sequencer #(
            .LAST_STEP (LP_LAST[g]),
            .PRESCALE  (LP_PRE[g])
        ) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (u_if)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: running flag, current step, cycles left in this step.
    typedef struct {
        bit run;
        bit hld;
        int step;
        int left;
        bit strobe;
        bit done;
    } mdl_t;

    mdl_t m [NDUT];

    function automatic int eff_last(int i);
        return (LP_LAST[i] > 9) ? 9 : int'(LP_LAST[i]);
    endfunction

    function automatic int eff_pre(int i);
        return (LP_PRE[i] == 0) ? 1 : int'(LP_PRE[i]);
    endfunction

    function automatic mdl_t mnext(mdl_t x, int i);
        mdl_t y = x;
        y.strobe = 0;
        y.done   = 0;
        if (rst || ab) begin
            y.run = 0;
            y.hld = 0;
        end else if (ce) begin
            if (!x.run) begin
                if (st) begin
                    y.run = 1; y.hld = 0; y.step = 0;
                    y.left = eff_pre(i); y.strobe = 1;
                end
            end else if (hd) begin
                y.hld = 1;
            end else begin
                y.hld  = 0;
                y.left = x.left - 1;
                if (y.left == 0) begin
                    if (x.step == eff_last(i)) begin
                        y.run = 0; y.done = 1;
                    end else begin
                        y.step = x.step + 1; y.left = eff_pre(i); y.strobe = 1;
                    end
                end
            end
        end
        return y;
    endfunction

    function automatic logic [7:0] mexp(mdl_t x);
        logic [3:0] code;
        code = x.run ? 4'(x.step) : 4'hF;
        return {x.done, x.strobe, x.run & x.hld, x.run, code};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) m[i] = mnext(m[i], i);
        @(negedge clk);
        if (chk_model)
            for (int i = 0; i < NDUT; i++)
                chk($sformatf("model_dut%0d", i), obs[i], mexp(m[i]));
    endtask

    task automatic set_in(input logic r, input logic e, input logic s,
                          input logic h, input logic a);
        rst = r; ce = e; st = s; hd = h; ab = a;
    endtask

    typedef struct {
        logic       r, e, s, h, a;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [14];

    initial begin : main
        int c5, hc, sc, cur;
        logic [3:0] code;
        logic reached;

        for (int i = 0; i < NDUT; i++) m[i] = '{0, 0, 0, 1, 0, 0};
        set_in(1, 0, 0, 0, 0);

        // Reset, then a full 0..9 run at PRESCALE 1 (DUT 0 and the clamped DUT 3).
        tbl[0] = '{1, 1, 0, 0, 0, 8'h0F};
        tbl[1] = '{1, 1, 0, 0, 0, 8'h0F};
        tbl[2] = '{0, 1, 1, 0, 0, 8'h50};
        for (int k = 1; k <= 9; k++) tbl[2 + k] = '{0, 1, 0, 0, 0, 8'h50 | 8'(k)};
        tbl[12] = '{0, 1, 0, 0, 0, 8'h8F};
        tbl[13] = '{0, 1, 0, 0, 0, 8'h0F};

        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].h, tbl[i].a);
            tick();
            chk($sformatf("tbl%0d_dut0", i), obs[0], tbl[i].exp);
            chk($sformatf("tbl%0d_dut3", i), obs[3], tbl[i].exp);
        end

        // LAST_STEP=2, PRESCALE=3 timing on DUT 1.
        set_in(1, 1, 0, 0, 0); tick();
        set_in(0, 1, 1, 0, 0); tick();
        chk("pre3_k1", obs[1], 8'h50);
        set_in(0, 1, 0, 0, 0);
        for (int k = 2; k <= 10; k++) begin
            logic [7:0] e;
            tick();
            if (k == 10) e = 8'h8F;
            else e = {1'b0, ((k - 1) % 3 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1, 4'((k - 1) / 3)};
            chk($sformatf("pre3_k%0d", k), obs[1], e);
        end

        // Hold for 4 cycles while showing code 5 on DUT 0.
        set_in(1, 1, 0, 0, 0); tick();
        set_in(0, 1, 1, 0, 0); tick();
        set_in(0, 1, 0, 0, 0);
        for (int n = 0; n < 20 && obs[0][3:0] != 4'd5; n++) tick();
        code = obs[0][3:0];
        chk("hold_reach5", 8'(code), 8'd5);
        c5 = 1; hc = 0; sc = int'(obs[0][6]);
        hd = 1;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (obs[0][3:0] == 4'd5) begin c5++; sc += int'(obs[0][6]); end
            if (obs[0][5]) hc++;
        end
        hd = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (obs[0][5]) hc++;
            if (obs[0][3:0] != 4'd5) break;
            c5++; sc += int'(obs[0][6]);
        end
        chk("hold_code5_len", 8'(c5), 8'd5);
        chk("hold_held_len", 8'(hc), 8'd4);
        chk("hold_strobes", 8'(sc), 8'd1);
        chk("hold_next6", obs[0], 8'h56);

        // Abort at code 7; start together with abort in IDLE.
        reached = 0;
        for (int n = 0; n < 20 && !reached; n++) begin
            if (obs[0][3:0] == 4'd7) reached = 1;
            else tick();
        end
        chk("abort_reach7", 8'(reached), 8'd1);
        ab = 1; tick();
        chk("abort_idle", obs[0], 8'h0F);
        ab = 0; tick();
        chk("abort_nodone", obs[0], 8'h0F);
        st = 1; ab = 1; tick();
        chk("start_abort", obs[0], 8'h0F);
        st = 0; ab = 0; tick();
        chk("start_abort_after", obs[0], 8'h0F);
        ce = 0; st = 1; tick();
        chk("start_no_ce", obs[0], 8'h0F);

        // Alternating ce, then reset while at code 4.
        set_in(0, 1, 1, 0, 0); tick();
        chk("ce_alt_start", obs[0], 8'h50);
        st = 0; cur = 0;
        for (int i = 0; i < 8; i++) begin
            ce = (i % 2 == 1);
            tick();
            if (ce) cur++;
            chk($sformatf("ce_alt%0d", i), obs[0], {2'b00, 1'b0, 1'b1, 4'(cur)} | (ce ? 8'h40 : 8'h00));
        end
        set_in(1, 1, 0, 0, 0); tick();
        chk("rst_mid", obs[0], 8'h0F);
        set_in(0, 1, 0, 0, 0); tick();
        chk("rst_mid_nodone", obs[0], 8'h0F);
        set_in(1, 0, 0, 0, 1); tick();
        chk("rst_over_abort", obs[0], 8'h0F);

        // Randomized traffic against the model on all DUTs.
        chk_model = 1;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            ab  = ($urandom_range(0, 39) == 0);
            ce  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            hd  = ($urandom_range(0, 5) == 0);
            tick();
        end
        chk_model = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
